rom_loader: RTL and testbench



---
 rtl/rom_pkg.sv | 14 +
 rtl/bram_sdp.sv | 43 ++++
 rtl/rom_loader.sv | 101 ++++++++++
 tb/tb_rom_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the run-time loadable ROM blocks: loader state encoding
// and the default word/address geometry used by the ROM family.
package rom_pkg;

    localparam int ROM_DATA_WIDTH = 20;
    localparam int ROM_ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read-first read port.
// Contents are never cleared; only the read register is reset.
module bram_sdp
    import rom_pkg::*;
#(
    parameter int DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of mem on the same edge as a write gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Streams handshaked words into an internal block RAM from address 0 and exposes
// a 1-cycle-latency read port, so consumers see a ROM filled at run time.
module rom_loader
    import rom_pkg::*;
#(
    parameter int DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int LOAD_COUNT = 2 ** ROM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH + 1)'(LOAD_COUNT - 1);

    load_state_t           state;
    load_state_t           state_next;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  accept;
    logic                  clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_addr  <= '0;
            wr_count <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                wr_addr  <= '0;
                wr_count <= '0;
            end else if (accept) begin
                // wr_addr may roll over after the final word; in_ready is already low by then.
                wr_addr  <= wr_addr + 1'b1;
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (in_valid && (wr_count == LAST_COUNT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    clear      = 1'b1;
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    bram_sdp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid)
    );

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: full 64-word instance plus a 4-word instance
// for the stall pattern; all expectations are hand-derived constants.
module tb_rom_loader;

    localparam int DW = 20;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    logic          start_4 = 1'b0;
    logic          in_valid_4 = 1'b0;
    logic          in_ready_4;
    logic [DW-1:0] in_data_4 = '0;
    logic          busy_4;
    logic          done_4;
    logic [AW:0]   wr_count_4;
    logic          rd_en_4 = 1'b0;
    logic [AW-1:0] rd_addr_4 = '0;
    logic [DW-1:0] rd_data_4;
    logic          rd_valid_4;

    int total = 0;
    int bad = 0;
    int busy_cycles;

    always #5 clk = ~clk;

    rom_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_COUNT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .done(done), .wr_count(wr_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    rom_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_4), .in_valid(in_valid_4), .in_ready(in_ready_4),
        .in_data(in_data_4), .busy(busy_4), .done(done_4), .wr_count(wr_count_4),
        .rd_en(rd_en_4), .rd_addr(rd_addr_4), .rd_data(rd_data_4), .rd_valid(rd_valid_4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic read4_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        rd_en_4   = 1'b1;
        rd_addr_4 = a;
        step();
        rd_en_4 = 1'b0;
        check(tag, 32'(rd_data_4), 32'(exp));
    endtask

    initial begin
        logic [6:0] pat_valid [7];
        logic [DW-1:0] exp_word;
        int k;

        // ---- reset ----
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst4_in_ready", 32'(in_ready_4), 32'd0);

        // ---- full load, 64 words, in_valid held high ----
        start = 1'b1;
        step();
        start = 1'b0;
        check("full_busy_start", 32'(busy), 32'd1);
        check("full_ready_start", 32'(in_ready), 32'd1);
        check("full_count_start", 32'(wr_count), 32'd0);
        in_valid = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 64; i++) begin
            in_data = DW'(i);
            if (busy) busy_cycles++;
            step();
        end
        check("full_busy_cycles", 32'(busy_cycles), 32'd64);
        check("full_done", 32'(done), 32'd1);
        check("full_wr_count", 32'(wr_count), 32'd64);
        check("full_busy_end", 32'(busy), 32'd0);
        check("full_ready_end", 32'(in_ready), 32'd0);

        // ---- in_valid in DONE is ignored ----
        in_data = 20'hFFFFF;
        step();
        step();
        in_valid = 1'b0;
        check("done_ign_count", 32'(wr_count), 32'd64);
        check("done_ign_done", 32'(done), 32'd1);

        read_check(6'd0,  20'h00000, "full_rd0");
        read_check(6'd31, 20'h0001F, "full_rd31");
        read_check(6'd63, 20'h0003F, "full_rd63");
        step();
        check("rd_idle_valid", 32'(rd_valid), 32'd0);
        check("rd_idle_hold", 32'(rd_data), 32'h3F);

        // ---- stall pattern on LOAD_COUNT=4 instance ----
        pat_valid = '{7'd1, 7'd0, 7'd0, 7'd1, 7'd1, 7'd0, 7'd1};
        start_4 = 1'b1;
        step();
        start_4 = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid_4 = pat_valid[i][0];
            if (pat_valid[i][0]) begin
                in_data_4 = DW'(20'hA + k);
                k++;
            end else begin
                in_data_4 = 20'hFFFFF;
            end
            if (i == 4) check("stall_count_mid", 32'(wr_count_4), 32'd2);
            step();
        end
        check("stall_done", 32'(done_4), 32'd1);
        check("stall_wr_count", 32'(wr_count_4), 32'd4);
        check("stall_ready_after", 32'(in_ready_4), 32'd0);
        in_data_4 = 20'hFFFFF;
        step();
        in_valid_4 = 1'b0;
        check("stall_no_extra", 32'(wr_count_4), 32'd4);
        read4_check(6'd0, 20'h0000A, "stall_rd0");
        read4_check(6'd1, 20'h0000B, "stall_rd1");
        read4_check(6'd2, 20'h0000C, "stall_rd2");
        read4_check(6'd3, 20'h0000D, "stall_rd3");

        // ---- reload from DONE with a start pulse mid-load ----
        start = 1'b1;
        step();
        start = 1'b0;
        check("reload_done_drop", 32'(done), 32'd0);
        check("reload_count_zero", 32'(wr_count), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = (i == 5) ? 20'h0AAAA : DW'(20'h50000 + i);
            start   = (i == 20);
            step();
            if (i == 20) check("reload_start_ignored", 32'(wr_count), 32'd21);
        end
        start = 1'b0;
        in_valid = 1'b0;
        check("reload_done", 32'(done), 32'd1);
        check("reload_wr_count", 32'(wr_count), 32'd64);
        for (int a = 0; a < 64; a++) begin
            exp_word = (a == 5) ? 20'h0AAAA : DW'(20'h50000 + a);
            read_check(AW'(a), exp_word, "reload_rd");
        end

        // ---- partial load with read-first collision, then reset mid-load ----
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = (i == 5) ? 20'h12345 : DW'(20'h100 + i);
            rd_en   = (i == 5) || (i == 6);
            rd_addr = 6'd5;
            step();
            if (i == 5) check("collide_old", 32'(rd_data), 32'h0AAAA);
            if (i == 6) check("collide_new", 32'(rd_data), 32'h12345);
        end
        rd_en = 1'b0;
        in_valid = 1'b0;
        check("partial_count", 32'(wr_count), 32'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_count", 32'(wr_count), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        in_data = 20'hFFFFF;
        step();
        step();
        in_valid = 1'b0;
        check("idle_ign_count", 32'(wr_count), 32'd0);
        check("idle_ign_done", 32'(done), 32'd0);
        read_check(6'd0,  20'h00100, "midrst_rd0");
        read_check(6'd5,  20'h12345, "midrst_rd5");
        read_check(6'd9,  20'h00109, "midrst_rd9");
        read_check(6'd10, 20'h5000A, "midrst_rd10");

        // new start restarts at address 0
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 20'h00777;
        step();
        in_valid = 1'b0;
        check("restart_count", 32'(wr_count), 32'd1);
        read_check(6'd0, 20'h00777, "restart_rd0");
        read_check(6'd1, 20'h00101, "restart_rd1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
